i2c_codec_cmd_sched: RTL

Scheduler that owns the shared WM8731 I2C command port (24-bit word / GO / END / ACK controller) and sequences every write to the codec.
- After reset it plays a fixed 9-command boot table.
- It then arbitrates between a host register-write requester and automatic headphone-volume updates.
- It retries NACKed writes, times out hung transfers, and reports status.
- It sits between the audio top level and the I2C controller. It replaces the free-running config loop.

---
 rtl/i2c_codec_cmd_sched_if.sv | 26 ++
 rtl/i2c_codec_cmd_sched.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_cmd_sched_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// i2c_codec_cmd_sched_if : WM8731 I2C command port and host write handshake
// Revision 1.0
// -----------------------------------------------------------------------------
interface i2c_codec_cmd_sched_if;
  logic [23:0] i2c_data;
  logic        i2c_go;
  logic        i2c_end;
  logic [2:0]  i2c_ack;
  logic        host_req;
  logic [6:0]  host_reg;
  logic [8:0]  host_data;
  logic        host_done;

  modport master (
    output i2c_data, i2c_go, host_done,
    input  i2c_end, i2c_ack, host_req, host_reg, host_data
  );

  modport slave (
    input  i2c_data, i2c_go, host_done,
    output i2c_end, i2c_ack, host_req, host_reg, host_data
  );
endinterface
`default_nettype wire

// File: rtl/i2c_codec_cmd_sched.sv
`default_nettype none
// -----------------------------------------------------------------------------
// i2c_codec_cmd_sched : boot table, host/volume arbitration, retry and timeout
// Revision 1.0
// -----------------------------------------------------------------------------
module i2c_codec_cmd_sched #(
  parameter logic [6:0] DEV_ADDR   = 7'h1A,
  parameter int         BOOT_DELAY = 16,
  parameter int         TIMEOUT    = 4096,
  parameter int         MAX_RETRY  = 2
) (
  input  wire logic              clk_i2c,
  input  wire logic              reset_n,
  input  wire logic [6:0]        vol,
  i2c_codec_cmd_sched_if.master  bus,
  output logic                   init_done,
  output logic                   busy,
  output logic                   cfg_err,
  output logic [3:0]             cmd_idx
);

  localparam logic [2:0] c_ST_BOOT    = 3'd0;
  localparam logic [2:0] c_ST_LOAD    = 3'd1;
  localparam logic [2:0] c_ST_WAIT_LO = 3'd2;
  localparam logic [2:0] c_ST_WAIT_HI = 3'd3;
  localparam logic [2:0] c_ST_NEXT    = 3'd4;
  localparam logic [2:0] c_ST_IDLE    = 3'd5;

  localparam logic [1:0] c_SRC_BOOT = 2'd0;
  localparam logic [1:0] c_SRC_VOL  = 2'd1;
  localparam logic [1:0] c_SRC_HOST = 2'd2;

  localparam int c_BCNT_W = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY + 1) : 1;
  localparam int c_TMR_W  = (TIMEOUT > 1)    ? $clog2(TIMEOUT)        : 1;
  localparam int c_RTY_W  = (MAX_RETRY > 0)  ? $clog2(MAX_RETRY + 1)  : 1;

  logic [2:0]          r_state;
  logic [1:0]          r_src;
  logic                r_vol_phase;
  logic [c_BCNT_W-1:0] r_boot_cnt;
  logic [c_TMR_W-1:0]  r_timer;
  logic [c_RTY_W-1:0]  r_retry;
  logic                r_nack;
  logic [8:0]          r_vol_snap;
  logic [6:0]          r_vol_sent;
  logic [6:0]          r_host_reg;
  logic [8:0]          r_host_data;
  logic [6:0]          w_reg;
  logic [8:0]          w_dat;
  logic                w_tmo;

  assign busy  = (r_state != c_ST_IDLE);
  assign w_tmo = (r_timer == c_TMR_W'(TIMEOUT - 1));

  // Register/data pair for whichever source owns the next LOAD
  always_comb begin
    w_reg = 7'h00;
    w_dat = 9'h000;
    case (r_src)
      c_SRC_BOOT: begin
        case (cmd_idx)
          4'd0: begin w_reg = 7'h0F; w_dat = 9'h000;     end
          4'd1: begin w_reg = 7'h06; w_dat = 9'h000;     end
          4'd2: begin w_reg = 7'h08; w_dat = 9'h002;     end
          4'd3: begin w_reg = 7'h02; w_dat = r_vol_snap; end
          4'd4: begin w_reg = 7'h03; w_dat = r_vol_snap; end
          4'd5: begin w_reg = 7'h07; w_dat = 9'h001;     end
          4'd6: begin w_reg = 7'h09; w_dat = 9'h001;     end
          4'd7: begin w_reg = 7'h04; w_dat = 9'h016;     end
          4'd8: begin w_reg = 7'h05; w_dat = 9'h006;     end
          default: begin w_reg = 7'h00; w_dat = 9'h000; end
        endcase
      end
      c_SRC_VOL: begin
        w_reg = r_vol_phase ? 7'h03 : 7'h02;
        w_dat = r_vol_snap;
      end
      default: begin
        w_reg = r_host_reg;
        w_dat = r_host_data;
      end
    endcase
  end

  always_ff @(posedge clk_i2c) begin
    if (!reset_n) begin
      r_state       <= c_ST_BOOT;
      r_src         <= c_SRC_BOOT;
      r_vol_phase   <= 1'b0;
      r_boot_cnt    <= '0;
      r_timer       <= '0;
      r_retry       <= '0;
      r_nack        <= 1'b0;
      r_vol_snap    <= '0;
      r_vol_sent    <= '0;
      r_host_reg    <= '0;
      r_host_data   <= '0;
      bus.i2c_data  <= '0;
      bus.i2c_go    <= 1'b0;
      bus.host_done <= 1'b0;
      init_done     <= 1'b0;
      cfg_err       <= 1'b0;
      cmd_idx       <= '0;
    end else begin
      bus.host_done <= 1'b0;
      case (r_state)
        c_ST_BOOT: begin
          if (r_boot_cnt == c_BCNT_W'(BOOT_DELAY - 1)) begin
            r_vol_snap <= {2'b00, vol};
            r_vol_sent <= vol;
            r_src      <= c_SRC_BOOT;
            r_state    <= c_ST_LOAD;
          end else begin
            r_boot_cnt <= r_boot_cnt + 1'b1;
          end
        end
        c_ST_LOAD: begin
          bus.i2c_data <= {DEV_ADDR, 1'b0, w_reg, w_dat};
          bus.i2c_go   <= 1'b1;
          r_timer      <= '0;
          r_nack       <= 1'b0;
          r_state      <= c_ST_WAIT_LO;
        end
        c_ST_WAIT_LO: begin
          if (!bus.i2c_end) begin
            r_timer <= '0;
            r_state <= c_ST_WAIT_HI;
          end else if (w_tmo) begin
            bus.i2c_go <= 1'b0;
            cfg_err    <= 1'b1;
            r_state    <= c_ST_NEXT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        c_ST_WAIT_HI: begin
          if (bus.i2c_end) begin
            bus.i2c_go <= 1'b0;
            r_nack     <= |bus.i2c_ack;
            r_state    <= c_ST_NEXT;
          end else if (w_tmo) begin
            bus.i2c_go <= 1'b0;
            cfg_err    <= 1'b1;
            r_state    <= c_ST_NEXT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        c_ST_NEXT: begin
          // A timed-out transfer leaves r_nack clear, so it is never retried
          if (r_nack && (r_retry < c_RTY_W'(MAX_RETRY))) begin
            r_retry <= r_retry + 1'b1;
            r_state <= c_ST_LOAD;
          end else begin
            if (r_nack) cfg_err <= 1'b1;
            r_retry <= '0;
            case (r_src)
              c_SRC_BOOT: begin
                if (cmd_idx == 4'd8) begin
                  init_done <= 1'b1;
                  r_state   <= c_ST_IDLE;
                end else begin
                  cmd_idx <= cmd_idx + 4'd1;
                  r_state <= c_ST_LOAD;
                end
              end
              c_SRC_VOL: begin
                if (!r_vol_phase) begin
                  r_vol_phase <= 1'b1;
                  r_state     <= c_ST_LOAD;
                end else begin
                  r_state <= c_ST_IDLE;
                end
              end
              default: begin
                bus.host_done <= 1'b1;
                r_state       <= c_ST_IDLE;
              end
            endcase
          end
        end
        c_ST_IDLE: begin
          if (init_done && bus.host_req) begin
            r_host_reg  <= bus.host_reg;
            r_host_data <= bus.host_data;
            r_src       <= c_SRC_HOST;
            r_state     <= c_ST_LOAD;
          end else if (vol != r_vol_sent) begin
            r_vol_snap  <= {2'b00, vol};
            r_vol_sent  <= vol;
            r_src       <= c_SRC_VOL;
            r_vol_phase <= 1'b0;
            r_state     <= c_ST_LOAD;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
